// File: rtl/str_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : str_accel_pkg
// Purpose  : Shared constants for the string-compare accelerator: FSM state
//            encoding, Avalon-MM register addresses, CTRL/status bit
//            positions and a small count-saturation helper.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package str_accel_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Register word addresses
    localparam logic [2:0] c_addr_push_a = 3'd0;
    localparam logic [2:0] c_addr_push_b = 3'd1;
    localparam logic [2:0] c_addr_ctrl   = 3'd2;
    localparam logic [2:0] c_addr_result = 3'd3;
    localparam logic [2:0] c_addr_count  = 3'd4;

    // CTRL write bits
    localparam int c_ctrl_go     = 0;
    localparam int c_ctrl_clear  = 1;
    localparam int c_ctrl_irq_en = 2;

    // CTRL read (status) bits
    localparam int c_stat_done   = 0;
    localparam int c_stat_busy   = 1;
    localparam int c_stat_irq_en = 2;
    localparam int c_stat_ovf    = 3;

    // RESULT equal flag position
    localparam int c_res_equal   = 31;

    // A FIFO holding DEPTH=256 words has a 9-bit count; the COUNT register
    // only has 8 bits per FIFO, so saturate rather than wrap to zero.
    function automatic logic [7:0] f_sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO. The head word is always visible on
//            data_o while the FIFO is not empty. flush_i empties the FIFO and
//            wins over a push or pop in the same cycle.
// Ports    : clk_i, rst_i (async, active-high)
//            push_i/data_i   - write a word (ignored when full)
//            pop_i           - drop the head word (ignored when empty)
//            flush_i         - discard all contents
//            data_o          - head word
//            full_o/empty_o  - occupancy flags
//            last_o          - exactly one word held
//            count_o         - number of words held
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;

    logic w_push_ok;
    logic w_pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign last_o    = (count_q == CW'(1));
    assign count_o   = count_q;
    assign data_o    = mem_q[rptr_q];

    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/str_cmp_avalon.sv
`default_nettype none
// ============================================================================
// Module   : str_cmp_avalon
// Purpose  : Avalon-MM string comparator. Software pushes two strings word by
//            word into FIFO A and FIFO B, writes go, and the engine compares
//            one word pair per cycle until a mismatch, a NUL terminator, or
//            the end of either string. Result and done status are then
//            readable, with an optional level interrupt.
// Ports    : clock      - sole clock (rising edge)
//            reset      - asynchronous, active-high
//            chipselect, read, write, address[2:0], writedata - Avalon slave
//            readdata   - registered read data, 1-cycle latency
//            irq        - done AND irq_en
// Registers: 0 push A (WO), 1 push B (WO), 2 CTRL, 3 RESULT (RO),
//            4 COUNT (RO), 5-7 read as zero
// Revision : 1.0 - initial release
// Note     : DATA_W is expected to be a multiple of 8 and at least 32 so the
//            RESULT/COUNT layouts fit.
// ============================================================================
module str_cmp_avalon
    import str_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int NBYTES = DATA_W / 8;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_rd;
    logic w_push_a_req;
    logic w_push_b_req;
    logic w_push_a_ok;
    logic w_push_b_ok;
    logic w_ctrl_wr;
    logic w_go;
    logic w_clear;
    logic w_result_rd;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q,   state_d;
    logic        go_pend_q, go_pend_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        res_eq_q,  res_eq_d;
    logic [15:0] res_idx_q, res_idx_d;
    logic        ovf_q,     ovf_d;
    logic        irq_en_q,  irq_en_d;

    logic        w_pop;
    logic        w_enter_done;
    logic        w_flush;

    // ------------------------------------------------------------------
    // FIFO interface
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_head_a,  w_head_b;
    logic              w_full_a,  w_full_b;
    logic              w_empty_a, w_empty_b;
    logic              w_last_a,  w_last_b;
    logic [CNT_W-1:0]  w_count_a, w_count_b;

    logic [31:0]       w_rd32;

    function automatic logic f_has_nul(input logic [DATA_W-1:0] word);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            if (word[i*8 +: 8] == 8'h00) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign w_wr         = chipselect && write;
    assign w_rd         = chipselect && read;
    assign w_push_a_req = w_wr && (address == c_addr_push_a);
    assign w_push_b_req = w_wr && (address == c_addr_push_b);
    assign w_ctrl_wr    = w_wr && (address == c_addr_ctrl);
    assign w_go         = w_ctrl_wr && writedata[c_ctrl_go];
    assign w_clear      = w_ctrl_wr && writedata[c_ctrl_clear];
    assign w_result_rd  = w_rd && (address == c_addr_result);

    // Strings are only loaded while idle; anything else is an overflow.
    assign w_push_a_ok  = w_push_a_req && (state_q == c_st_idle) && !w_full_a;
    assign w_push_b_ok  = w_push_b_req && (state_q == c_st_idle) && !w_full_b;

    assign w_flush      = w_clear || w_enter_done;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_a (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (w_push_a_ok),
        .data_i  (writedata),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_o  (w_head_a),
        .full_o  (w_full_a),
        .empty_o (w_empty_a),
        .last_o  (w_last_a),
        .count_o (w_count_a)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_b (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (w_push_b_ok),
        .data_i  (writedata),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_o  (w_head_b),
        .full_o  (w_full_b),
        .empty_o (w_empty_b),
        .last_o  (w_last_b),
        .count_o (w_count_b)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // go is latched for one cycle before it is acted on, so the decision
    // is made on FIFO counts that already include any push sampled on the
    // same edge as go. This gives done one edge after the last compare.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        go_pend_d    = 1'b0;
        cnt_d        = cnt_q;
        res_eq_d     = res_eq_q;
        res_idx_d    = res_idx_q;
        ovf_d        = ovf_q;
        irq_en_d     = irq_en_q;
        w_pop        = 1'b0;
        w_enter_done = 1'b0;

        if (w_ctrl_wr) begin
            irq_en_d = writedata[c_ctrl_irq_en];
        end

        if ((w_push_a_req && !w_push_a_ok) || (w_push_b_req && !w_push_b_ok)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            c_st_idle: begin
                if (go_pend_q) begin
                    cnt_d = 16'd0;
                    if (w_empty_a && w_empty_b) begin
                        state_d      = c_st_done;
                        res_eq_d     = 1'b1;
                        res_idx_d    = 16'd0;
                        w_enter_done = 1'b1;
                    end else if (w_empty_a || w_empty_b) begin
                        // One string has length zero: shorter length is 0.
                        state_d      = c_st_done;
                        res_eq_d     = 1'b0;
                        res_idx_d    = 16'd0;
                        w_enter_done = 1'b1;
                    end else begin
                        state_d = c_st_run;
                    end
                end else if (w_go) begin
                    go_pend_d = 1'b1;
                end
            end

            c_st_run: begin
                // Both FIFOs are non-empty here: RUN is only entered with
                // data on both sides and is left as soon as either side
                // presents its last word.
                w_pop = 1'b1;
                if (w_head_a != w_head_b) begin
                    state_d      = c_st_done;
                    res_eq_d     = 1'b0;
                    res_idx_d    = cnt_q;
                    w_enter_done = 1'b1;
                end else if (f_has_nul(w_head_a) || (w_last_a && w_last_b)) begin
                    state_d      = c_st_done;
                    res_eq_d     = 1'b1;
                    res_idx_d    = cnt_q + 16'd1;
                    w_enter_done = 1'b1;
                end else if (w_last_a || w_last_b) begin
                    state_d      = c_st_done;
                    res_eq_d     = 1'b0;
                    res_idx_d    = cnt_q + 16'd1;
                    w_enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            c_st_done: begin
                if (w_result_rd) begin
                    state_d = c_st_idle;
                end
            end

            default: begin
                state_d = c_st_idle;
            end
        endcase

        // clear overrides everything, including a go in the same write.
        if (w_clear) begin
            state_d      = c_st_idle;
            go_pend_d    = 1'b0;
            cnt_d        = 16'd0;
            res_eq_d     = 1'b0;
            res_idx_d    = 16'd0;
            ovf_d        = 1'b0;
            w_enter_done = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= c_st_idle;
            go_pend_q <= 1'b0;
            cnt_q     <= 16'd0;
            res_eq_q  <= 1'b0;
            res_idx_q <= 16'd0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_pend_q <= go_pend_d;
            cnt_q     <= cnt_d;
            res_eq_q  <= res_eq_d;
            res_idx_q <= res_idx_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rd32 = 32'h0;
        case (address)
            c_addr_ctrl: begin
                w_rd32[c_stat_done]   = (state_q == c_st_done);
                w_rd32[c_stat_busy]   = (state_q == c_st_run);
                w_rd32[c_stat_irq_en] = irq_en_q;
                w_rd32[c_stat_ovf]    = ovf_q;
            end
            c_addr_result: begin
                w_rd32[c_res_equal] = res_eq_q;
                w_rd32[15:0]        = res_idx_q;
            end
            c_addr_count: begin
                w_rd32[15:8] = f_sat8(16'(w_count_b));
                w_rd32[7:0]  = f_sat8(16'(w_count_a));
            end
            default: begin
                w_rd32 = 32'h0;
            end
        endcase
    end

    // A RESULT read returns the value captured here, before the state
    // change to IDLE takes effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (w_rd) begin
            readdata <= DATA_W'(w_rd32);
        end
    end

    assign irq = (state_q == c_st_done) && irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_str_cmp_avalon.sv
`default_nettype none
// ============================================================================
// Module   : tb_str_cmp_avalon
// Purpose  : Self-checking bench for str_cmp_avalon: directed scenarios plus
//            randomized string pairs checked against a reference model of the
//            comparison rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_str_cmp_avalon;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    localparam logic [2:0] A_PUSH_A = 3'd0;
    localparam logic [2:0] A_PUSH_B = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_RESULT = 3'd3;
    localparam logic [2:0] A_COUNT  = 3'd4;

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              chipselect = 1'b0;
    logic              read       = 1'b0;
    logic              write      = 1'b0;
    logic [2:0]        address    = 3'd0;
    logic [DATA_W-1:0] writedata  = '0;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clock = ~clock;

    str_cmp_avalon #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    // ---------------- bus helpers (called at a falling edge) -------------
    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clock);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic push_strings();
        foreach (qa[i]) av_write(A_PUSH_A, qa[i]);
        foreach (qb[i]) av_write(A_PUSH_B, qb[i]);
    endtask

    // Writes CTRL and counts edges until irq rises (bounded).
    task automatic go_and_wait(input logic [31:0] ctrl, output int cyc);
        av_write(A_CTRL, ctrl);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // ---------------- reference model ------------------------------------
    function automatic bit has_nul(input logic [31:0] w);
        for (int i = 0; i < 4; i++) if (w[i*8 +: 8] == 8'h00) return 1'b1;
        return 1'b0;
    endfunction

    // Expected RESULT and number of word pairs compared for qa/qb.
    function automatic void model(output logic [31:0] res, output int n);
        int la = qa.size();
        int lb = qb.size();
        res = 32'h0;
        n   = 0;
        if (la == 0 && lb == 0) begin
            res = 32'h8000_0000;
            return;
        end
        for (int i = 0; i < la && i < lb; i++) begin
            n = i + 1;
            if (qa[i] != qb[i]) begin
                res = 32'(i);
                return;
            end
            if (has_nul(qa[i]) || (i == la - 1 && i == lb - 1)) begin
                res = 32'h8000_0000 | 32'(i + 1);
                return;
            end
            if (i == la - 1 || i == lb - 1) begin
                res = 32'(i + 1);
                return;
            end
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'($urandom_range(1, 255));
        return w;
    endfunction

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", d, 32'h0); end
        av_read(A_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_nul_terminated();
        logic [31:0] d;
        int cyc;
        qa = {32'h6463_6261, 32'h0000_6665};   // "abcd", "ef\0\0"
        qb = {32'h6463_6261, 32'h0000_6665};
        push_strings();
        av_read(A_COUNT, d);
        checks++; if (d !== 32'h0000_0202) begin errors++; $display("FAIL nul_count_loaded: got %h expected %h", d, 32'h0000_0202); end
        go_and_wait(32'h5, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL nul_done_latency: got %0d expected 3", cyc); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL nul_irq: got %b expected 1", irq); end
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL nul_result: got %h expected %h", d, 32'h8000_0002); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nul_irq_cleared: got %b expected 0", irq); end
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL nul_ctrl_after: got %h expected %h", d, 32'h4); end
    endtask

    task automatic test_mismatch();
        logic [31:0] d;
        int cyc;
        qa = {32'h6463_6261, 32'h6563_6261};   // "abcd", "abce"
        qb = {32'h6463_6261, 32'h6663_6261};   // "abcd", "abcf"
        push_strings();
        go_and_wait(32'h5, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL mismatch_latency: got %0d expected 3", cyc); end
        av_read(A_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mismatch_count: got %h expected %h", d, 32'h0); end
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL mismatch_result: got %h expected %h", d, 32'h0000_0001); end
    endtask

    task automatic test_length_diff();
        logic [31:0] d;
        int cyc;
        qa = {32'h6463_6261, 32'h6867_6665, 32'h6C6B_6A69};
        qb = {32'h6463_6261, 32'h6867_6665};
        push_strings();
        go_and_wait(32'h5, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL length_latency: got %0d expected 3", cyc); end
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL length_result: got %h expected %h", d, 32'h0000_0002); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        av_write(A_CTRL, 32'h2);   // clear, irq_en off
        for (int i = 0; i < DEPTH + 1; i++) av_write(A_PUSH_A, 32'h1111_1111 + 32'(i));
        av_read(A_COUNT, d);
        checks++; if (d !== 32'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %h expected %h", d, 32'(DEPTH)); end
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL ovf_ctrl: got %h expected %h", d, 32'h8); end
        av_write(A_CTRL, 32'h2);
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_clear_ctrl: got %h expected %h", d, 32'h0); end
        av_read(A_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_clear_count: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_empty_go();
        logic [31:0] d;
        int cyc;
        qa = {};
        qb = {};
        go_and_wait(32'h5, cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL empty_latency: got %0d expected 1", cyc); end
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL empty_result: got %h expected %h", d, 32'h8000_0000); end
        av_read(A_CTRL, d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL empty_done_cleared: got %b expected 0", d[0]); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        int cyc;
        qa = {};
        for (int i = 0; i < 6; i++) qa.push_back(rand_word());
        qb = qa;
        push_strings();
        av_write(A_CTRL, 32'h1);     // go, irq_en off
        @(negedge clock);
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL midrun_busy: got %h expected %h", d, 32'h2); end
        #2 reset = 1'b1;
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midrun_readdata: got %h expected %h", readdata, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_irq: got %b expected 0", irq); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        av_read(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_ctrl_after: got %h expected %h", d, 32'h0); end
        av_read(A_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_count_after: got %h expected %h", d, 32'h0); end
        qa = {32'h6463_6261, 32'h0000_6665};
        qb = {32'h6463_6261, 32'h0000_6665};
        push_strings();
        go_and_wait(32'h5, cyc);
        av_read(A_RESULT, d);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL midrun_fresh_result: got %h expected %h", d, 32'h8000_0002); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        int cyc, n, la, lb, p;
        for (int it = 0; it < 12; it++) begin
            la = $urandom_range(1, 6);
            lb = $urandom_range(1, 6);
            qa = {};
            qb = {};
            for (int i = 0; i < la; i++) qa.push_back(rand_word());
            if ($urandom_range(0, 2) == 0) begin
                p = $urandom_range(0, la - 1);
                qa[p][8*$urandom_range(0, 3) +: 8] = 8'h00;
            end
            for (int i = 0; i < lb; i++) qb.push_back((i < la) ? qa[i] : rand_word());
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, ((la < lb) ? la : lb) - 1);
                qb[p] = qb[p] ^ (32'h1 << $urandom_range(0, 31));
            end
            model(exp, n);
            push_strings();
            av_read(A_COUNT, d);
            checks++; if (d !== {16'h0, 8'(lb), 8'(la)}) begin errors++; $display("FAIL rand%0d_count: got %h expected %h", it, d, {16'h0, 8'(lb), 8'(la)}); end
            go_and_wait(32'h5, cyc);
            checks++; if (cyc != n + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, cyc, n + 1); end
            av_read(A_RESULT, d);
            checks++; if (d !== exp) begin errors++; $display("FAIL rand%0d_result: got %h expected %h", it, d, exp); end
            av_read(A_CTRL, d);
            checks++; if (d !== 32'h4) begin errors++; $display("FAIL rand%0d_ctrl: got %h expected %h", it, d, 32'h4); end
            av_read(A_COUNT, d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL rand%0d_count_after: got %h expected %h", it, d, 32'h0); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_nul_terminated();
        test_mismatch();
        test_length_diff();
        test_overflow();
        test_empty_go();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/str_cmp_avalon.md
STR_CMP_AVALON -- requirements
Module: str_cmp_avalon

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width; four 8-bit characters per word at 32.
REQ-002 SHALL have parameter DEPTH, default 16, meaning words per string FIFO; power of two, 2..256.
REQ-003 SHALL have ports: clock  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-005 SHALL have ports: chipselect  in  1  Avalon-MM slave select.
REQ-006 SHALL have ports: read  in  1  Avalon-MM read strobe.
REQ-007 SHALL have ports: write  in  1  Avalon-MM write strobe.
REQ-008 SHALL have ports: address  in  3  word register index.
REQ-009 SHALL have ports: writedata  in  DATA_W  write data.
REQ-010 SHALL have ports: readdata  out  DATA_W  registered read data.
REQ-011 SHALL have ports: irq  out  1  level interrupt = done AND irq_en.

Function
REQ-012 SHALL map registers:
- 0: write-only push to FIFO A (string A).
- 1: write-only push to FIFO B (string B).
- 2: CTRL. Write: bit0 go, bit1 clear, bit2 irq_en (stored). Read: bit0 done, bit1 busy, bit2 irq_en, bit3 overflow.
- 3: RESULT, read-only. Bit31 equal; [15:0] index.
- 4: COUNT, read-only. [15:8] FIFO B count; [7:0] FIFO A count.
- 5-7: read as 0; writes ignored.
REQ-013 SHALL update readdata on the edge after a cycle with chipselect&&read (1-cycle latency) and hold it otherwise.
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: pushes accepted.
- go with both FIFOs empty: -> DONE, equal=1, index=0.
- go otherwise: -> RUN.
REQ-015 SHALL, in each RUN cycle, pop one word from each FIFO and compare them; index counts words that compared equal.
REQ-016 SHALL leave RUN for DONE when any of the following holds:
- (a) mismatch: equal=0, index=position of the mismatching word.
- (b) matched word from A contains a 0x00 byte: equal=1.
- (c) both popped words are the last in their FIFOs: equal=1.
- (d) exactly one popped word is the last in its FIFO: equal=0, index=shorter length.
REQ-017 SHALL flush both FIFOs on DONE entry.
REQ-018 SHALL give done=1 at edge T+N+1, where go is written at edge T and N word pairs are compared.
REQ-019 SHALL make busy=1 in RUN only.
REQ-020 SHALL leave DONE for IDLE on a RESULT read (chipselect&&read, address 3), clearing done/irq; readdata returns the pre-clear RESULT.
REQ-021 SHALL ignore go while in RUN or DONE.
REQ-022 SHALL treat clear in any state as:
- next state IDLE;
- both FIFOs flushed;
- RESULT and overflow zeroed;
- clear wins over a simultaneous go.
REQ-023 SHALL drop pushes to a full FIFO, or made outside IDLE, and set sticky overflow (cleared only by clear/reset).
REQ-024 SHALL apply a simultaneous push and go: the push first, then go evaluated on the updated counts.

Reset
REQ-025 SHALL, on reset, asynchronously force:
- state IDLE;
- FIFOs empty;
- readdata, RESULT, irq_en, overflow, done, irq all 0.
Reset mid-RUN SHALL abort with no residual state.

Structure
REQ-026 SHALL place the state enum, register address constants and CTRL bit positions in package str_accel_pkg.
REQ-027 SHALL instantiate sub-module sync_fifo (params DATA_W, DEPTH; push/pop/flush, full/empty/last/count) twice.

Verification
REQ-028 SHALL cover: push A={"abcd","ef\0\0"}, B identical, go -> done at T+3, RESULT=0x8000_0002, irq=1 when irq_en.
REQ-029 SHALL cover: A={"abcd","abce"}, B={"abcd","abcf"}, go -> RESULT=0x0000_0001, COUNT=0 after done.
REQ-030 SHALL cover: A=3 words, B=2 matching words (no NUL), go -> RESULT=0x0000_0002.
REQ-031 SHALL cover: DEPTH+1 pushes to A -> COUNT[7:0]=DEPTH, CTRL overflow=1; clear -> CTRL=0, COUNT=0.
REQ-032 SHALL cover: go with empty FIFOs -> done next edge, RESULT=0x8000_0000; RESULT read -> done=0.
REQ-033 SHALL cover: reset asserted mid-RUN -> all outputs 0 immediately; a fresh compare succeeds afterwards.
